// File: rtl/act_tile_fetch.sv
// rtl/act_tile_fetch.sv - assembles 4x4-spatial x 4-channel activation tiles from SRAM group A
module act_tile_fetch #(
  parameter int CH_NUM       = 4,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 8,
  parameter int BLK_DIM      = 7,
  parameter int ADDR_STRIDE  = 6
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  output logic                                        busy,
  output logic                                        done,
  output logic [5:0]                                  sram_raddr_a0,
  output logic [5:0]                                  sram_raddr_a1,
  output logic [5:0]                                  sram_raddr_a2,
  output logic [5:0]                                  sram_raddr_a3,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]   sram_rdata_a0,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]   sram_rdata_a1,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]   sram_rdata_a2,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]   sram_rdata_a3,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [4*CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] out_data,
  output logic [2:0]                                  out_row,
  output logic [2:0]                                  out_col,
  output logic                                        out_last
);
  localparam int WORD_W = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
  localparam int TILE_W = 4 * WORD_W;
  localparam int IDX_W  = $clog2(TILE_W);
  localparam int WIDX_W = $clog2(WORD_W);
  localparam logic [2:0] LAST_POS = 3'(BLK_DIM - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [2:0]          by_q, bx_q, nxt_by, nxt_bx, tgt_by, tgt_bx;
  logic                inflight_q;
  logic [2:0]          if_by_q, if_bx_q;
  logic [5:0]          raddr_q [4];
  logic [WORD_W-1:0]   rdata [4];
  logic [TILE_W-1:0]   mem_data [2];
  logic [2:0]          mem_row [2];
  logic [2:0]          mem_col [2];
  logic                mem_last [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          count_q;
  logic                pop, can_issue, issue, load_first, advance, last_tile;
  logic [TILE_W-1:0]   asm_data;
  logic [IDX_W-1:0]    dst_hi;
  logic [WIDX_W-1:0]   src_hi;

  // Bank b={p,q} of tile (by,bx) holds block (by+i, bx+j) with i=p^by[0], j=q^bx[0].
  function automatic logic [5:0] blk_addr(input logic [2:0] by, input logic [2:0] bx, input int b);
    logic [2:0] r, c;
    r = by + {2'b00, by[0] ^ (b / 2 != 0)};
    c = bx + {2'b00, bx[0] ^ (b % 2 != 0)};
    return 6'(ADDR_STRIDE * int'(r[2:1]) + int'(c[2:1]));
  endfunction

  assign rdata[0] = sram_rdata_a0;
  assign rdata[1] = sram_rdata_a1;
  assign rdata[2] = sram_rdata_a2;
  assign rdata[3] = sram_rdata_a3;
  assign sram_raddr_a0 = raddr_q[0];
  assign sram_raddr_a1 = raddr_q[1];
  assign sram_raddr_a2 = raddr_q[2];
  assign sram_raddr_a3 = raddr_q[3];

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_data[rd_ptr_q];
  assign out_row   = mem_row[rd_ptr_q];
  assign out_col   = mem_col[rd_ptr_q];
  assign out_last  = out_valid && mem_last[rd_ptr_q];

  assign pop       = out_valid && out_ready;
  // Credit check: FIFO occupancy plus the read in flight must leave room for this issue.
  assign can_issue = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign last_tile = (by_q == LAST_POS) && (bx_q == LAST_POS);
  assign nxt_bx    = (bx_q == LAST_POS) ? 3'd0 : bx_q + 3'd1;
  assign nxt_by    = (bx_q == LAST_POS) ? by_q + 3'd1 : by_q;
  assign advance   = load_first || (issue && !last_tile);
  assign tgt_by    = load_first ? 3'd0 : nxt_by;
  assign tgt_bx    = load_first ? 3'd0 : nxt_bx;

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    load_first = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          load_first = 1'b1;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        issue = can_issue;
        if (issue && last_tile) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (count_q == 2'd0 && !inflight_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scatter the four bank words into tile slots ch*16 + Y*4 + X using the in-flight tag parity.
  always_comb begin
    asm_data = '0;
    dst_hi   = '0;
    src_hi   = '0;
    for (int b = 0; b < 4; b++) begin
      for (int ch = 0; ch < CH_NUM; ch++) begin
        for (int y = 0; y < 2; y++) begin
          for (int x = 0; x < 2; x++) begin
            dst_hi = IDX_W'(TILE_W - 1 - BW_PER_ACT * (ch * 16
                     + (2 * ((b / 2) ^ int'(if_by_q[0])) + y) * 4
                     + 2 * ((b % 2) ^ int'(if_bx_q[0])) + x));
            src_hi = WIDX_W'(WORD_W - 1 - BW_PER_ACT * (ch * 4 + y * 2 + x));
            asm_data[dst_hi -: BW_PER_ACT] = rdata[b][src_hi -: BW_PER_ACT];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      by_q       <= '0;
      bx_q       <= '0;
      inflight_q <= 1'b0;
      if_by_q    <= '0;
      if_bx_q    <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
      for (int b = 0; b < 4; b++) raddr_q[b] <= '0;
      for (int e = 0; e < 2; e++) begin
        mem_data[e] <= '0;
        mem_row[e]  <= '0;
        mem_col[e]  <= '0;
        mem_last[e] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      // Address registers always track the next tile to issue, so they hold while stalled.
      if (advance) begin
        by_q <= tgt_by;
        bx_q <= tgt_bx;
        for (int b = 0; b < 4; b++) raddr_q[b] <= blk_addr(tgt_by, tgt_bx, b);
      end
      inflight_q <= issue;
      if (issue) begin
        if_by_q <= by_q;
        if_bx_q <= bx_q;
      end
      if (inflight_q) begin
        mem_data[wr_ptr_q] <= asm_data;
        mem_row[wr_ptr_q]  <= if_by_q;
        mem_col[wr_ptr_q]  <= if_bx_q;
        mem_last[wr_ptr_q] <= (if_by_q == LAST_POS) && (if_bx_q == LAST_POS);
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_act_tile_fetch.sv
// tb/tb_act_tile_fetch.sv - randomized self-checking bench for act_tile_fetch
module tb_act_tile_fetch;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic         busy, done, out_valid, out_last;
  logic [5:0]   ra0, ra1, ra2, ra3;
  logic [127:0] rd0 = '0, rd1 = '0, rd2 = '0, rd3 = '0;
  logic [511:0] out_data;
  logic [2:0]   out_row, out_col;
  logic [127:0] mem [4][64];
  int           n_checks = 0;
  int           n_fail = 0;
  int           done_cnt = 0;
  logic [511:0] acc_data [$];
  int           acc_row [$];
  int           acc_col [$];
  bit           acc_last [$];

  always #5 clk = ~clk;

  act_tile_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .sram_raddr_a0(ra0), .sram_raddr_a1(ra1), .sram_raddr_a2(ra2), .sram_raddr_a3(ra3),
    .sram_rdata_a0(rd0), .sram_rdata_a1(rd1), .sram_rdata_a2(rd2), .sram_rdata_a3(rd3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  // SRAM: data appears the cycle after the address
  always @(posedge clk) begin
    rd0 <= mem[0][ra0];
    rd1 <= mem[1][ra1];
    rd2 <= mem[2][ra2];
    rd3 <= mem[3][ra3];
  end

  // Reference: tile covers blocks rows by..by+1, cols bx..bx+1 of the 14x14 map
  function automatic logic [511:0] exp_tile(input int by, input int bx);
    logic [511:0] t;
    logic [127:0] w;
    int r, c, s;
    t = '0;
    for (int ch = 0; ch < 4; ch++)
      for (int yy = 0; yy < 4; yy++)
        for (int xx = 0; xx < 4; xx++) begin
          r = by + yy / 2;
          c = bx + xx / 2;
          s = ch * 4 + (yy % 2) * 2 + xx % 2;
          w = mem[(r % 2) * 2 + c % 2][6 * (r / 2) + c / 2];
          t[511 - 8 * (ch * 16 + yy * 4 + xx) -: 8] = w[127 - 8 * s -: 8];
        end
    return t;
  endfunction

  function automatic logic [23:0] exp_addrs(input int by, input int bx);
    logic [23:0] v;
    int r, c;
    v = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        r = by + i;
        c = bx + j;
        v[23 - 6 * ((r % 2) * 2 + c % 2) -: 6] = 6'(6 * (r / 2) + c / 2);
      end
    return v;
  endfunction

  task automatic fill_mem();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++)
        mem[b][a] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic clear_acc();
    acc_data.delete();
    acc_row.delete();
    acc_col.delete();
    acc_last.delete();
    done_cnt = 0;
  endtask

  task automatic step(input bit rdy);
    @(negedge clk);
    out_ready = rdy;
    if (out_valid && rdy) begin
      acc_data.push_back(out_data);
      acc_row.push_back(int'(out_row));
      acc_col.push_back(int'(out_col));
      acc_last.push_back(out_last);
    end
    if (done) done_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, out_valid, out_last} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 0000", {busy, done, out_valid, out_last});
    end
    n_checks++;
    if (out_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", out_data);
    end
    n_checks++;
    if ({out_row, out_col, ra0, ra1, ra2, ra3} !== 30'b0) begin
      n_fail++; $display("FAIL reset_tag_addr: got %h required 0", {out_row, out_col, ra0, ra1, ra2, ra3});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_throughput();
    bit ev;
    int t;
    fill_mem();
    clear_acc();
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1'b1);
      start = 1'b0;
      ev = (k >= 3 && k <= 38);
      n_checks++;
      if (out_valid !== ev) begin
        n_fail++; $display("FAIL tp_valid cycle %0d: got %b required %b", k, out_valid, ev);
      end
      n_checks++;
      if (busy !== (k >= 1 && k <= 38)) begin
        n_fail++; $display("FAIL tp_busy cycle %0d: got %b", k, busy);
      end
      n_checks++;
      if (done !== (k == 39)) begin
        n_fail++; $display("FAIL tp_done cycle %0d: got %b", k, done);
      end
      n_checks++;
      if (out_last !== (k == 38)) begin
        n_fail++; $display("FAIL tp_last cycle %0d: got %b", k, out_last);
      end
      if (k <= 36) begin
        t = k - 1;
        n_checks++;
        if ({ra0, ra1, ra2, ra3} !== exp_addrs(t / 6, t % 6)) begin
          n_fail++; $display("FAIL tp_addr tile %0d: got %h required %h", t, {ra0, ra1, ra2, ra3}, exp_addrs(t / 6, t % 6));
        end
      end
      if (k == 10) begin
        n_checks++;
        if ({ra0, ra1, ra2, ra3} !== {6'd8, 6'd7, 6'd2, 6'd1}) begin
          n_fail++; $display("FAIL addr_tile_1_3: got %0d %0d %0d %0d required 8 7 2 1", ra0, ra1, ra2, ra3);
        end
      end
      if (ev) begin
        t = k - 3;
        n_checks++;
        if (out_row !== 3'(t / 6) || out_col !== 3'(t % 6) || out_data !== exp_tile(t / 6, t % 6)) begin
          n_fail++; $display("FAIL tp_tile %0d: got (%0d,%0d) %h required %h", t, out_row, out_col, out_data, exp_tile(t / 6, t % 6));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] snap;
    int k;
    fill_mem();
    clear_acc();
    @(negedge clk);
    start = 1'b1;
    k = 0;
    while (acc_data.size() < 7 && k < 60) begin
      step(1'b1);
      start = 1'b0;
      k++;
    end
    snap = '0;
    for (int s = 0; s < 10; s++) begin
      step(1'b0);
      if (s == 0) begin
        snap = {ra0, ra1, ra2, ra3};
        n_checks++;
        if (snap !== exp_addrs(1, 3)) begin
          n_fail++; $display("FAIL bp_addr_stall: got %h required %h", snap, exp_addrs(1, 3));
        end
      end else begin
        n_checks++;
        if ({ra0, ra1, ra2, ra3} !== snap) begin
          n_fail++; $display("FAIL bp_addr_hold stall %0d: got %h required %h", s, {ra0, ra1, ra2, ra3}, snap);
        end
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_row !== 3'd1 || out_col !== 3'd1 || out_data !== exp_tile(1, 1)) begin
        n_fail++; $display("FAIL bp_frozen stall %0d: got v=%b (%0d,%0d) %h", s, out_valid, out_row, out_col, out_data);
      end
    end
    k = 0;
    while (done_cnt == 0 && k < 600) begin
      step(1'($urandom_range(0, 1)));
      k++;
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL bp_done: got %0d pulses required 1", done_cnt);
    end
    n_checks++;
    if (acc_data.size() != 36) begin
      n_fail++; $display("FAIL bp_count: got %0d tiles required 36", acc_data.size());
    end
    for (int i = 0; i < acc_data.size() && i < 36; i++) begin
      n_checks++;
      if (acc_row[i] != i / 6 || acc_col[i] != i % 6 || acc_last[i] != (i == 35) || acc_data[i] !== exp_tile(i / 6, i % 6)) begin
        n_fail++; $display("FAIL bp_tile %0d: got (%0d,%0d) last=%b %h", i, acc_row[i], acc_col[i], acc_last[i], acc_data[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int k;
    fill_mem();
    clear_acc();
    @(negedge clk);
    start = 1'b1;
    k = 0;
    while (done_cnt == 0 && k < 600) begin
      step(1'($urandom_range(0, 1)));
      start = busy;
      k++;
    end
    start = 1'b0;
    repeat (6) step(1'b1);
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL si_done: got %0d pulses busy=%b required 1 pulse busy=0", done_cnt, busy);
    end
    n_checks++;
    if (acc_data.size() != 36) begin
      n_fail++; $display("FAIL si_count: got %0d tiles required 36", acc_data.size());
    end
    for (int i = 0; i < acc_data.size() && i < 36; i++) begin
      n_checks++;
      if (acc_row[i] != i / 6 || acc_col[i] != i % 6 || acc_data[i] !== exp_tile(i / 6, i % 6)) begin
        n_fail++; $display("FAIL si_tile %0d: got (%0d,%0d) %h", i, acc_row[i], acc_col[i], acc_data[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    fill_mem();
    clear_acc();
    @(negedge clk);
    start = 1'b1;
    k = 0;
    while (acc_data.size() < 20 && k < 60) begin
      step(1'b1);
      start = 1'b0;
      k++;
    end
    rst_n = 1'b0;
    step(1'b1);
    n_checks++;
    if ({busy, done, out_valid, out_last, out_row, out_col} !== 10'b0 || out_data !== '0) begin
      n_fail++; $display("FAIL rm_outputs: got flags %b tag %0d,%0d data %h", {busy, done, out_valid, out_last}, out_row, out_col, out_data);
    end
    n_checks++;
    if ({ra0, ra1, ra2, ra3} !== 24'b0) begin
      n_fail++; $display("FAIL rm_addr: got %h required 0", {ra0, ra1, ra2, ra3});
    end
    rst_n = 1'b1;
    repeat (8) step(1'b1);
    n_checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rm_no_done: got %0d pulses busy=%b", done_cnt, busy);
    end
    fill_mem();
    clear_acc();
    @(negedge clk);
    start = 1'b1;
    k = 0;
    while (done_cnt == 0 && k < 200) begin
      step(1'b1);
      start = 1'b0;
      k++;
    end
    n_checks++;
    if (done_cnt != 1 || acc_data.size() != 36) begin
      n_fail++; $display("FAIL rm_rerun: got %0d pulses %0d tiles required 1 and 36", done_cnt, acc_data.size());
    end
    for (int i = 0; i < acc_data.size() && i < 36; i++) begin
      n_checks++;
      if (acc_row[i] != i / 6 || acc_col[i] != i % 6 || acc_data[i] !== exp_tile(i / 6, i % 6)) begin
        n_fail++; $display("FAIL rm_tile %0d: got (%0d,%0d) %h", i, acc_row[i], acc_col[i], acc_data[i]);
      end
    end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_throughput();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
